// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// requests onto an 8-bit RAM port, with a write stall for the IO buffer window.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IC_rn,
    input  logic [31:0] IC_addr,
    output logic        IC_ready,
    output logic [31:0] IC_value,
    input  logic        LS_en,
    input  logic        LS_wr,
    input  logic [1:0]  LS_len,
    input  logic [31:0] LS_addr,
    input  logic [31:0] LS_wdata,
    output logic        LS_ready,
    output logic [31:0] LS_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sel_ic;
    logic        r_prio_ls;
    logic        r_rdy_q;
    logic [2:0]  r_n;
    logic [2:0]  r_issue;
    logic [2:0]  r_cap;
    logic        r_a_valid;
    logic        r_d_valid;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [31:0] r_mem_a;
    logic [31:0] r_ic_value;
    logic [31:0] r_ls_rdata;
    logic [7:0]  r_mem_dout;
    logic        r_mem_wr;
    logic        r_ic_ready;
    logic        r_ls_ready;

    logic        w_grant_ls;
    logic        w_grant_ic;
    logic        w_accept;
    logic        w_acc_write;
    logic        w_acc_stall;
    logic        w_wr_stall;
    logic [2:0]  w_acc_n;
    logic [31:0] w_acc_addr;
    logic [31:0] w_wr_addr;
    logic [31:0] w_buf_next;
    logic [7:0]  w_wr_byte;
    logic        w_rd_last;
    logic        w_wr_done;

    function automatic logic is_io(input logic [15:0] addr_hi);
        return addr_hi == 16'h0003;
    endfunction

    // LS wins a tie when r_prio_ls is set; the pointer flips to the other side on every grant.
    assign w_grant_ls  = LS_en & (~IC_rn | r_prio_ls);
    assign w_grant_ic  = IC_rn & ~w_grant_ls;
    assign w_accept    = (r_state == S_IDLE) & (IC_rn | LS_en);
    assign w_acc_write = w_grant_ls & LS_wr;
    assign w_acc_addr  = w_grant_ic ? IC_addr : LS_addr;
    assign w_acc_n     = (w_grant_ic | LS_len[1]) ? 3'd4 : (LS_len[0] ? 3'd2 : 3'd1);
    assign w_acc_stall = is_io(w_acc_addr[31:16]) & io_buffer_full;
    assign w_wr_addr   = r_base + {29'd0, r_issue};
    assign w_wr_stall  = is_io(w_wr_addr[31:16]) & io_buffer_full;
    assign w_wr_byte   = r_wdata[{r_issue[1:0], 3'b000} +: 8];
    assign w_rd_last   = r_rdy_q & r_d_valid & (r_cap == (r_n - 3'd1));
    assign w_wr_done   = (r_issue == r_n);

    // Merge the byte arriving on mem_din into the assembled read word
    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{r_cap[1:0], 3'b000} +: 8] = mem_din;
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = w_acc_write ? S_WRITE : S_READ;
                else          w_state_next = S_IDLE;
            end
            S_READ: begin
                if (w_rd_last) w_state_next = S_IDLE;
                else           w_state_next = S_READ;
            end
            S_WRITE: begin
                if (w_wr_done) w_state_next = S_IDLE;
                else           w_state_next = S_WRITE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register, frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst)      r_state <= S_IDLE;
        else if (rdy) r_state <= w_state_next;
        else          r_state <= r_state;
    end

    // Datapath: request latch, RAM address/data pipeline, result and ready registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_ic   <= 1'b0;
            r_prio_ls  <= 1'b1;
            r_rdy_q    <= 1'b1;
            r_n        <= 3'd0;
            r_issue    <= 3'd0;
            r_cap      <= 3'd0;
            r_a_valid  <= 1'b0;
            r_d_valid  <= 1'b0;
            r_base     <= 32'd0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
            r_ic_ready <= 1'b0;
            r_ls_ready <= 1'b0;
            r_ic_value <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else begin
            r_rdy_q <= rdy;
            if (rdy) begin
                r_mem_wr   <= 1'b0;
                r_ic_ready <= 1'b0;
                r_ls_ready <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_sel_ic  <= w_grant_ic;
                            r_prio_ls <= w_grant_ic;
                            r_n       <= w_acc_n;
                            r_base    <= w_acc_addr;
                            r_wdata   <= LS_wdata;
                            r_buf     <= 32'd0;
                            r_cap     <= 3'd0;
                            r_d_valid <= 1'b0;
                            r_a_valid <= ~w_acc_write;
                            if (w_acc_write && w_acc_stall) begin
                                r_issue <= 3'd0;
                            end else begin
                                r_mem_a <= w_acc_addr;
                                r_issue <= 3'd1;
                                if (w_acc_write) begin
                                    r_mem_dout <= LS_wdata[7:0];
                                    r_mem_wr   <= 1'b1;
                                end
                            end
                        end
                    end
                    S_READ: begin
                        // After a pause the RAM output is stale: restart from the next uncaptured byte.
                        if (!r_rdy_q) begin
                            r_mem_a   <= r_base + {29'd0, r_cap};
                            r_issue   <= r_cap + 3'd1;
                            r_a_valid <= 1'b1;
                            r_d_valid <= 1'b0;
                        end else begin
                            if (r_d_valid) begin
                                r_buf <= w_buf_next;
                                r_cap <= r_cap + 3'd1;
                            end
                            if (w_rd_last) begin
                                if (r_sel_ic) begin
                                    r_ic_value <= w_buf_next;
                                    r_ic_ready <= 1'b1;
                                end else begin
                                    r_ls_rdata <= w_buf_next;
                                    r_ls_ready <= 1'b1;
                                end
                            end
                            r_d_valid <= r_a_valid;
                            if (r_issue < r_n) begin
                                r_mem_a   <= r_base + {29'd0, r_issue};
                                r_issue   <= r_issue + 3'd1;
                                r_a_valid <= 1'b1;
                            end else begin
                                r_a_valid <= 1'b0;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (w_wr_done) begin
                            r_ls_ready <= 1'b1;
                        end else if (!w_wr_stall) begin
                            r_mem_a    <= w_wr_addr;
                            r_mem_dout <= w_wr_byte;
                            r_mem_wr   <= 1'b1;
                            r_issue    <= r_issue + 3'd1;
                        end
                    end
                    default: r_mem_wr <= 1'b0;
                endcase
            end
        end
    end

    // Outputs: strobes are masked while the system is paused
    always_comb begin
        IC_ready = r_ic_ready & rdy;
        LS_ready = r_ls_ready & rdy;
        mem_wr   = r_mem_wr & rdy;
        IC_value = r_ic_value;
        LS_rdata = r_ls_rdata;
        mem_a    = r_mem_a;
        mem_dout = r_mem_dout;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of single transactions plus
// hand-written arbitration, IO stall, pause and reset sequences.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, IC_rn, IC_ready, LS_en, LS_wr, LS_ready, mem_wr, io_buffer_full;
    logic [31:0] IC_addr, IC_value, LS_addr, LS_wdata, LS_rdata, mem_a;
    logic [1:0]  LS_len;
    logic [7:0]  mem_din, mem_dout;
    logic [7:0]  ram [0:262143];

    int n_pass = 0;
    int n_total = 0;
    int both_hi = 0;

    int          rec_lat, rec_nwr;
    logic        rec_ic;
    logic [31:0] rec_ra [0:3];
    logic [31:0] rec_wa [0:3];
    logic [7:0]  rec_wd [0:3];

    typedef struct {
        logic        ic;
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_val;
        int          exp_lat;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .IC_rn(IC_rn), .IC_addr(IC_addr), .IC_ready(IC_ready), .IC_value(IC_value),
        .LS_en(LS_en), .LS_wr(LS_wr), .LS_len(LS_len), .LS_addr(LS_addr), .LS_wdata(LS_wdata),
        .LS_ready(LS_ready), .LS_rdata(LS_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // RAM: synchronous read, data one cycle after address
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    always @(negedge clk) if (IC_ready && LS_ready) both_hi++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // One request from a negedge; later input changes must be ignored by the DUT
    task automatic run(input logic ic, input logic wr, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata);
        rec_lat = 0;
        rec_nwr = 0;
        rec_ic  = 1'b0;
        if (ic) begin
            IC_rn = 1'b1; IC_addr = addr;
        end else begin
            LS_en = 1'b1; LS_wr = wr; LS_len = len; LS_addr = addr; LS_wdata = wdata;
        end
        for (int c = 1; c <= 40 && rec_lat == 0; c++) begin
            @(negedge clk);
            if (c <= 4) rec_ra[c-1] = mem_a;
            if (mem_wr) begin
                if (rec_nwr < 4) begin
                    rec_wa[rec_nwr] = mem_a;
                    rec_wd[rec_nwr] = mem_dout;
                end
                rec_nwr++;
            end
            if (c == 1) begin
                IC_addr = ~addr; LS_addr = ~addr; LS_wdata = ~wdata; LS_len = ~len; LS_wr = ~wr;
            end
            if (IC_ready || LS_ready) begin
                rec_lat = c;
                rec_ic  = IC_ready;
                IC_rn   = 1'b0;
                LS_en   = 1'b0;
            end
        end
    endtask

    // Raise both requesters together; report which one completed first
    task automatic pair(output logic first_ic, output int n_done);
        logic got_ic, got_ls, first_set;
        got_ic = 1'b0; got_ls = 1'b0; first_set = 1'b0; first_ic = 1'b0;
        IC_rn = 1'b1; IC_addr = 32'h0000_1000;
        LS_en = 1'b1; LS_wr = 1'b0; LS_len = 2'b00; LS_addr = 32'h0000_2002;
        for (int c = 0; c < 60 && !(got_ic && got_ls); c++) begin
            @(negedge clk);
            if ((IC_ready || LS_ready) && !first_set) begin
                first_ic  = IC_ready;
                first_set = 1'b1;
            end
            if (IC_ready) begin got_ic = 1'b1; IC_rn = 1'b0; end
            if (LS_ready) begin got_ls = 1'b1; LS_en = 1'b0; end
        end
        n_done = int'(got_ic) + int'(got_ls);
    endtask

    initial begin
        int          n, lat, cnt, nwr, nrdy, n_done;
        logic        first_ic;
        logic [31:0] ea, tmp, wa;
        logic [7:0]  wd;

        vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0000_0000, 32'h0000_0513, 6};
        vecs[1] = '{1'b0, 1'b1, 2'b01, 32'h0000_2002, 32'hAABB_CCDD, 32'h0000_0000, 3};
        vecs[2] = '{1'b0, 1'b0, 2'b01, 32'h0000_2002, 32'h0000_0000, 32'h0000_CCDD, 4};
        vecs[3] = '{1'b0, 1'b1, 2'b10, 32'h0000_2010, 32'h1122_3344, 32'h0000_CCDD, 5};
        vecs[4] = '{1'b0, 1'b0, 2'b00, 32'h0000_2011, 32'h0000_0000, 32'h0000_0033, 3};
        vecs[5] = '{1'b0, 1'b0, 2'b11, 32'h0000_2010, 32'h0000_0000, 32'h1122_3344, 6};
        vecs[6] = '{1'b0, 1'b1, 2'b00, 32'h0000_2013, 32'h0000_00EE, 32'h1122_3344, 2};
        vecs[7] = '{1'b1, 1'b0, 2'b10, 32'h0000_2010, 32'h0000_0000, 32'hEE22_3344, 6};
        vecs[8] = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0000_0000, 32'hD4C3_B2A1, 6};
        vecs[9] = '{1'b0, 1'b0, 2'b00, 32'h0000_2002, 32'h0000_0000, 32'h0000_00DD, 3};

        for (int a = 0; a < 262144; a++) ram[a] = 8'h00;
        ram[18'h01000] = 8'h13; ram[18'h01001] = 8'h05;
        ram[18'h3FFFE] = 8'hA1; ram[18'h3FFFF] = 8'hB2;
        ram[18'h00000] = 8'hC3; ram[18'h00001] = 8'hD4;

        rst = 1'b1; rdy = 1'b0; IC_rn = 1'b0; LS_en = 1'b0; LS_wr = 1'b0; LS_len = 2'b00;
        IC_addr = 32'd0; LS_addr = 32'd0; LS_wdata = 32'd0; io_buffer_full = 1'b0;
        repeat (2) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        check("rst_ic_ready", {31'd0, IC_ready}, 32'd0);
        check("rst_ls_ready", {31'd0, LS_ready}, 32'd0);
        check("rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
        check("rst_mem_a",    mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_ic_value", IC_value, 32'd0);
        check("rst_ls_rdata", LS_rdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run(vecs[i].ic, vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata);
            n = vecs[i].ic ? 4 : (vecs[i].len == 2'b00 ? 1 : (vecs[i].len == 2'b01 ? 2 : 4));
            check($sformatf("v%0d_latency", i), rec_lat, vecs[i].exp_lat);
            check($sformatf("v%0d_ready_src", i), {31'd0, rec_ic}, {31'd0, vecs[i].ic});
            check($sformatf("v%0d_value", i), vecs[i].ic ? IC_value : LS_rdata, vecs[i].exp_val);
            if (vecs[i].wr) begin
                check($sformatf("v%0d_nwrites", i), rec_nwr, n);
                for (int k = 0; k < n; k++) begin
                    ea  = vecs[i].addr + 32'(k);
                    tmp = vecs[i].wdata >> (8 * k);
                    check($sformatf("v%0d_wr%0d_addr", i, k), rec_wa[k], ea);
                    check($sformatf("v%0d_wr%0d_data", i, k), {24'd0, rec_wd[k]}, {24'd0, tmp[7:0]});
                end
            end else begin
                check($sformatf("v%0d_no_writes", i), rec_nwr, 0);
                for (int k = 0; k < n; k++) begin
                    ea = vecs[i].addr + 32'(k);
                    check($sformatf("v%0d_rd%0d_addr", i, k), rec_ra[k], ea);
                end
            end
        end

        // Non-IO store proceeds even while the IO buffer is full
        @(negedge clk);
        io_buffer_full = 1'b1;
        run(1'b0, 1'b1, 2'b00, 32'h0000_2020, 32'h0000_0077);
        check("nonio_store_latency", rec_lat, 2);
        io_buffer_full = 1'b0;

        // Pause for two cycles after byte 1 of an IC fetch
        @(negedge clk);
        IC_rn = 1'b1; IC_addr = 32'h0000_1000;
        repeat (2) @(negedge clk);
        check("pause_pre_addr", mem_a, 32'h0000_1001);
        rdy = 1'b0;
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (IC_ready || mem_wr) cnt++;
        end
        check("pause_quiet", cnt, 0);
        check("pause_hold_value", IC_value, 32'hEE22_3344);
        rdy = 1'b1;
        @(negedge clk);
        check("resume_reissue_addr", mem_a, 32'h0000_1000);
        lat = 0;
        for (int c = 6; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (IC_ready) begin
                lat = c;
                IC_rn = 1'b0;
                check("pause_value", IC_value, 32'h0000_0513);
            end
        end
        check("pause_delayed", {31'd0, (lat >= 9 && lat <= 10)}, 32'd1);

        // Byte store into the IO window held off by io_buffer_full for three cycles
        @(negedge clk);
        io_buffer_full = 1'b1;
        LS_en = 1'b1; LS_wr = 1'b1; LS_len = 2'b00; LS_addr = 32'h0003_0000; LS_wdata = 32'h0000_005A;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr || LS_ready) cnt++;
        end
        check("io_stall_no_write", cnt, 0);
        io_buffer_full = 1'b0;
        nwr = 0; nrdy = 0; wa = 32'd0; wd = 8'd0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_wr) begin nwr++; wa = mem_a; wd = mem_dout; end
            if (LS_ready) begin nrdy++; LS_en = 1'b0; end
        end
        check("io_write_count", nwr, 1);
        check("io_write_addr", wa, 32'h0003_0000);
        check("io_write_data", {24'd0, wd}, 32'h0000_005A);
        check("io_ready_count", nrdy, 1);
        check("io_ram_byte", {24'd0, ram[18'h30000]}, 32'h0000_005A);

        // Reset in the middle of an IC fetch
        @(negedge clk);
        IC_rn = 1'b1; IC_addr = 32'h0000_1000;
        repeat (2) @(negedge clk);
        rst = 1'b1; IC_rn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_mem_a", mem_a, 32'd0);
        check("midrst_ic_value", IC_value, 32'd0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (IC_ready || LS_ready) cnt++;
        end
        check("midrst_no_ready", cnt, 0);

        // Round-robin: LS first out of reset, IC first after an LS-only access
        pair(first_ic, n_done);
        check("rr1_both_done", n_done, 2);
        check("rr1_ls_first", {31'd0, first_ic}, 32'd0);
        @(negedge clk);
        run(1'b0, 1'b0, 2'b00, 32'h0000_2002, 32'h0000_0000);
        check("rr_single_ls_value", LS_rdata, 32'h0000_00DD);
        @(negedge clk);
        pair(first_ic, n_done);
        check("rr2_both_done", n_done, 2);
        check("rr2_ic_first", {31'd0, first_ic}, 32'd1);
        check("rr2_ic_value", IC_value, 32'h0000_0513);

        check("never_both_ready", both_hi, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
